// File: rtl/ps2_rx_ctrl.sv
// PS/2 host receive controller: pin synchronisers, 11-bit frame sequencer with
// watchdog, first-word-fall-through scan-code FIFO and sticky error flags.
module ps2_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4095
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  input  logic                          err_clr
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sh, dat_sh;
  logic                   clk_prev, clk_sync, dat_sync, fall;

  state_t         state, state_n;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par;
  logic [WDW-1:0] wd;
  logic           timeout, push, set_perr, set_ferr;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           pop, full, do_push, drop;

  assign clk_sync = clk_sh[SYNC_STAGES-1];
  assign dat_sync = dat_sh[SYNC_STAGES-1];
  assign fall     = clk_prev & ~clk_sync;

  // Synchronisers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sh   <= '1;
      dat_sh   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sh   <= {clk_sh[SYNC_STAGES-2:0], ps2_clk};
      dat_sh   <= {dat_sh[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync;
    end
  end

  assign timeout = (state != IDLE) && !fall && (wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else if (timeout) begin
      state_n  = IDLE;
      set_ferr = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!dat_sync) state_n = DATA;
        DATA:   if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          // A bad stop bit masks any parity verdict.
          if (!dat_sync)        set_ferr = 1'b1;
          else if (^shreg ^ par) push    = 1'b1;
          else                   set_perr = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      wd      <= '0;
    end else begin
      if (fall || state_n == IDLE) wd <= '0;
      else                         wd <= wd + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (en && fall && state == DATA) begin
        shreg[bit_cnt] <= dat_sync;
        bit_cnt        <= bit_cnt + 3'd1;
      end
      if (en && fall && state == PARITY) par <= dat_sync;
    end
  end

  assign pop     = out_valid & out_ready;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];
  assign fifo_count = count;

  // Event beats a coincident clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overflow   <= drop     | (overflow   & ~err_clr);
      parity_err <= set_perr | (parity_err & ~err_clr);
      frame_err  <= set_ferr | (frame_err  & ~err_clr);
    end
  end
endmodule
